// File: rtl/adder_cla_arb.sv
// adder_cla_arb: two-requester round-robin arbiter that shares one NBIT-bit
// carry-lookahead adder between two clients, with multi-word bursts whose
// carry chains across cycles.
//
// Results leave through a one-entry registered output stage (valid/ready).
//
// Ports
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_reqN_valid             requester N presents a word (N = 0, 1)
//   o_reqN_ready             word from requester N accepted this cycle
//   i_reqN_a, i_reqN_b       operands
//   i_reqN_c                 carry-in, used only on the first word of a burst
//   i_reqN_last              final word of the burst
//   o_valid / i_ready        output handshake
//   o_s, o_c                 registered sum word and its carry-out
//   o_id                     requester that produced the result
//   o_last                   result is the final word of its burst
module adder_cla_arb #(
  parameter int unsigned NBIT = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,

  input  logic            i_req0_valid,
  output logic            o_req0_ready,
  input  logic [NBIT-1:0] i_req0_a,
  input  logic [NBIT-1:0] i_req0_b,
  input  logic            i_req0_c,
  input  logic            i_req0_last,

  input  logic            i_req1_valid,
  output logic            o_req1_ready,
  input  logic [NBIT-1:0] i_req1_a,
  input  logic [NBIT-1:0] i_req1_b,
  input  logic            i_req1_c,
  input  logic            i_req1_last,

  output logic            o_valid,
  input  logic            i_ready,
  output logic [NBIT-1:0] o_s,
  output logic            o_c,
  output logic            o_id,
  output logic            o_last
);

  // Adder is built from 4-bit lookahead groups; operands are zero-padded
  // up to a whole number of groups.
  localparam int unsigned NGrp = (NBIT + 3) / 4;
  localparam int unsigned PadW = NGrp * 4;

  typedef enum logic [1:0] {
    StIdle,
    StLock0,
    StLock1
  } state_e;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;          // IDLE tie-break: requester to favour
  logic            chain_c_q, chain_c_d;  // carry handed to the next burst word

  logic            out_valid_q, out_valid_d;
  logic [NBIT-1:0] out_s_q, out_s_d;
  logic            out_c_q, out_c_d;
  logic            out_id_q, out_id_d;
  logic            out_last_q, out_last_d;

  logic            grant0, grant1;
  logic            space;
  logic            accept;
  logic            sel_id;
  logic            sel_last;
  logic            sel_c;

  logic [NBIT-1:0] add_a, add_b;
  logic            add_cin;
  logic [NBIT-1:0] add_sum;
  logic            add_cout;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && !sel_last) begin
          state_d = sel_id ? StLock1 : StLock0;
        end
      end
      StLock0, StLock1: begin
        if (accept && sel_last) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (grants)
  // ---------------------------------------------------------------------------
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_req0_valid && i_req1_valid) begin
          grant0 = !ptr_q;
          grant1 = ptr_q;
        end else begin
          grant0 = i_req0_valid;
          grant1 = i_req1_valid;
        end
      end
      // A locked burst owns the adder until its last word; the other side waits.
      StLock0: grant0 = i_req0_valid;
      StLock1: grant1 = i_req1_valid;
      default: begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Handshake and operand selection
  // ---------------------------------------------------------------------------
  assign space        = !out_valid_q || i_ready;
  assign o_req0_ready = grant0 && space && !i_rst;
  assign o_req1_ready = grant1 && space && !i_rst;
  assign accept       = o_req0_ready || o_req1_ready;

  // Grants are exclusive, so grant1 alone steers the operand mux.
  assign sel_id   = grant1;
  assign add_a    = sel_id ? i_req1_a    : i_req0_a;
  assign add_b    = sel_id ? i_req1_b    : i_req0_b;
  assign sel_c    = sel_id ? i_req1_c    : i_req0_c;
  assign sel_last = sel_id ? i_req1_last : i_req0_last;

  // First word of a burst takes the requester's carry; later words take the
  // carry-out of the previous word.
  assign add_cin = (state_q == StIdle) ? sel_c : chain_c_q;

  // ---------------------------------------------------------------------------
  // Carry-lookahead adder (adder_cla datapath)
  // Each 4-bit group computes its internal carries directly from the group
  // carry-in; group carries then ripple through group generate/propagate.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic [PadW-1:0] pa, pb, gen, prop;
    logic [PadW:0]   cy;
    logic [3:0]      g4, p4;
    logic            cg, grp_g, grp_p;

    pa    = PadW'(add_a);
    pb    = PadW'(add_b);
    gen   = pa & pb;
    prop  = pa ^ pb;
    cy    = '0;
    cy[0] = add_cin;
    g4    = '0;
    p4    = '0;
    cg    = 1'b0;
    grp_g = 1'b0;
    grp_p = 1'b0;

    for (int unsigned grp = 0; grp < NGrp; grp++) begin
      g4 = gen[grp*4 +: 4];
      p4 = prop[grp*4 +: 4];
      cg = cy[grp*4];

      cy[grp*4+1] = g4[0] | (p4[0] & cg);
      cy[grp*4+2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cg);
      cy[grp*4+3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                  | (p4[2] & p4[1] & p4[0] & cg);

      grp_g = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
            | (p4[3] & p4[2] & p4[1] & g4[0]);
      grp_p = &p4;
      cy[grp*4+4] = grp_g | (grp_p & cg);
    end

    // Padding bits have p = g = 0, so cy[NBIT] is the true carry-out.
    add_sum  = prop[NBIT-1:0] ^ cy[NBIT-1:0];
    add_cout = cy[NBIT];
  end

  // ---------------------------------------------------------------------------
  // Pointer, chained carry and output stage next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    ptr_d       = ptr_q;
    chain_c_d   = chain_c_q;
    out_valid_d = out_valid_q;
    out_s_d     = out_s_q;
    out_c_d     = out_c_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;

    if (accept) begin
      chain_c_d   = add_cout;
      out_valid_d = 1'b1;
      out_s_d     = add_sum;
      out_c_d     = add_cout;
      out_id_d    = sel_id;
      out_last_d  = sel_last;
      // Fairness is per burst: the pointer only turns over on a last word.
      if (sel_last) begin
        ptr_d = ~sel_id;
      end
    end else if (i_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q       <= 1'b0;
      chain_c_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_s_q     <= '0;
      out_c_q     <= 1'b0;
      out_id_q    <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      chain_c_q   <= chain_c_d;
      out_valid_q <= out_valid_d;
      out_s_q     <= out_s_d;
      out_c_q     <= out_c_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_s     = out_s_q;
  assign o_c     = out_c_q;
  assign o_id    = out_id_q;
  assign o_last  = out_last_q;

  // Only one requester may ever be accepted in a cycle.
  a_ready_mutex : assert property (@(posedge i_clk) !(o_req0_ready && o_req1_ready));

endmodule

// File: tb/tb_adder_cla_arb.sv
// Self-checking bench for adder_cla_arb: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model, plus whole-burst wide-addition checks.
module tb_adder_cla_arb;

  localparam int unsigned NBIT = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            v0, r0, c0, l0;
  logic            v1, r1, c1, l1;
  logic [NBIT-1:0] a0, b0, a1, b1;
  logic            o_valid, rdy_in, oc, oid, olast;
  logic [NBIT-1:0] os;

  always #5 clk = ~clk;

  adder_cla_arb #(.NBIT(NBIT)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (v0),
    .o_req0_ready (r0),
    .i_req0_a     (a0),
    .i_req0_b     (b0),
    .i_req0_c     (c0),
    .i_req0_last  (l0),
    .i_req1_valid (v1),
    .o_req1_ready (r1),
    .i_req1_a     (a1),
    .i_req1_b     (b1),
    .i_req1_c     (c1),
    .i_req1_last  (l1),
    .o_valid      (o_valid),
    .i_ready      (rdy_in),
    .o_s          (os),
    .o_c          (oc),
    .o_id         (oid),
    .o_last       (olast)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [127:0] sum;
    int           n;
    logic         id;
  } burst_t;

  logic            m_valid = 1'b0, m_c = 1'b0, m_id = 1'b0, m_last = 1'b0;
  logic            m_ptr = 1'b0, m_carry = 1'b0;
  logic [NBIT-1:0] m_s = '0;
  int              m_owner = -1;
  int              m_cnt [2] = '{0, 0};
  logic [127:0]    acc_a [2];
  logic [127:0]    acc_b [2];
  logic            acc_c [2];
  burst_t          exp_q [$];

  // Which requester the rules say is accepted now; bit0 = req0, bit1 = req1.
  function automatic logic [1:0] exp_rdy();
    if (rst || !(!m_valid || rdy_in)) return 2'b00;
    if (m_owner == 0) return {1'b0, v0};
    if (m_owner == 1) return {v1, 1'b0};
    if (v0 && v1) return m_ptr ? 2'b10 : 2'b01;
    return {v1, v0};
  endfunction

  always @(posedge clk) begin : model
    logic [1:0]      rd;
    logic            id, cin, last;
    logic [NBIT-1:0] a, b;
    logic [NBIT:0]   r;
    logic [127:0]    na, nb;
    logic            nc;
    burst_t          bt;
    if (rst) begin
      m_valid  <= 1'b0;
      m_s      <= '0;
      m_c      <= 1'b0;
      m_id     <= 1'b0;
      m_last   <= 1'b0;
      m_owner  <= -1;
      m_ptr    <= 1'b0;
      m_carry  <= 1'b0;
      m_cnt[0] <= 0;
      m_cnt[1] <= 0;
      exp_q.delete();
    end else begin
      rd = exp_rdy();
      if (rd != 2'b00) begin
        id   = rd[1];
        a    = id ? a1 : a0;
        b    = id ? b1 : b0;
        last = id ? l1 : l0;
        cin  = (m_owner < 0) ? (id ? c1 : c0) : m_carry;
        r    = {1'b0, a} + {1'b0, b} + {{NBIT{1'b0}}, cin};
        m_valid <= 1'b1;
        m_s     <= r[NBIT-1:0];
        m_c     <= r[NBIT];
        m_id    <= id;
        m_last  <= last;
        m_carry <= r[NBIT];
        na = (m_cnt[id] == 0) ? 128'(a) : acc_a[id] | (128'(a) << (NBIT * m_cnt[id]));
        nb = (m_cnt[id] == 0) ? 128'(b) : acc_b[id] | (128'(b) << (NBIT * m_cnt[id]));
        nc = (m_cnt[id] == 0) ? cin : acc_c[id];
        if (last) begin
          bt.sum = na + nb + 128'(nc);
          bt.n   = m_cnt[id] + 1;
          bt.id  = id;
          exp_q.push_back(bt);
          m_cnt[id] <= 0;
          m_owner   <= -1;
          m_ptr     <= ~id;
        end else begin
          acc_a[id] <= na;
          acc_b[id] <= nb;
          acc_c[id] <= nc;
          m_cnt[id] <= m_cnt[id] + 1;
          m_owner   <= int'(id);
        end
      end else if (rdy_in) begin
        m_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare, plus reassembly of drained bursts into wide sums
  // ---------------------------------------------------------------------------
  logic [127:0] out_acc = '0;
  int           out_cnt = 0;

  always @(negedge clk) begin : cmp
    logic [1:0]   er;
    logic [127:0] acc;
    burst_t       bt;
    er = exp_rdy();
    chk("req0_ready", r0, er[0]);
    chk("req1_ready", r1, er[1]);
    chk("o_valid", o_valid, m_valid);
    chk("o_s", os, m_s);
    chk("o_c", oc, m_c);
    chk("o_id", oid, m_id);
    chk("o_last", olast, m_last);
    if (rst) begin
      out_acc <= '0;
      out_cnt <= 0;
    end else if (o_valid && rdy_in) begin
      acc = out_acc | (128'(os) << (NBIT * out_cnt));
      if (olast) begin
        acc = acc | (128'(oc) << (NBIT * (out_cnt + 1)));
        chk("burst_queued", 64'(exp_q.size()), 64'd1);
        if (exp_q.size() != 0) begin
          bt = exp_q.pop_front();
          chk("burst_sum_lo", acc[63:0], bt.sum[63:0]);
          chk("burst_sum_hi", acc[127:64], bt.sum[127:64]);
          chk("burst_words", 64'(out_cnt + 1), 64'(bt.n));
          chk("burst_id", oid, bt.id);
        end
        out_acc <= '0;
        out_cnt <= 0;
      end else begin
        out_acc <= acc;
        out_cnt <= out_cnt + 1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    v0  = 1'b0;
    v1  = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] exp_ids;
    rst = 1'b1; rdy_in = 1'b0;
    v0 = 1'b0; a0 = '0; b0 = '0; c0 = 1'b0; l0 = 1'b0;
    v1 = 1'b0; a1 = '0; b1 = '0; c1 = 1'b0; l1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_valid", o_valid, 0);
    chk("rst_s", os, 0);
    chk("rst_id", oid, 0);

    // Single word from req0.
    rdy_in = 1'b1;
    v0 = 1'b1; a0 = 5; b0 = 7; c0 = 1'b1; l0 = 1'b1;
    #1 chk("t1_ready0", r0, 1);
    tick();
    v0 = 1'b0;
    chk("t1_valid", o_valid, 1);
    chk("t1_s", os, 13);
    chk("t1_c", oc, 0);
    chk("t1_id", oid, 0);
    chk("t1_last", olast, 1);
    tick();
    chk("t1_drain", o_valid, 0);

    // 64-bit burst on req1; second word's own carry-in must be ignored.
    v1 = 1'b1; a1 = 32'hFFFF_FFFF; b1 = 1; c1 = 1'b0; l1 = 1'b0;
    #1 chk("t2_ready1_w0", r1, 1);
    tick();
    a1 = 0; b1 = 0; c1 = 1'b1; l1 = 1'b1;
    chk("t2_s0", os, 0);
    chk("t2_c0", oc, 1);
    chk("t2_last0", olast, 0);
    #1 chk("t2_ready1_w1", r1, 1);
    tick();
    v1 = 1'b0;
    chk("t2_s1", os, 1);
    chk("t2_c1", oc, 0);
    chk("t2_last1", olast, 1);
    chk("t2_id", oid, 1);
    tick();

    // Both valid with single words: strict alternation from req0.
    do_reset();
    exp_ids = 4'b1010;
    v0 = 1'b1; a0 = 1; b0 = 1; c0 = 1'b0; l0 = 1'b1;
    v1 = 1'b1; a1 = 2; b1 = 2; c1 = 1'b0; l1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_ready0", r0, !exp_ids[k]);
      chk("t3_ready1", r1, exp_ids[k]);
      tick();
      chk("t3_id", oid, exp_ids[k]);
    end
    v0 = 1'b0; v1 = 1'b0;
    tick();

    // req0 3-word burst locks out a waiting req1.
    do_reset();
    exp_ids = 4'b1000;
    v1 = 1'b1; a1 = 3; b1 = 4; c1 = 1'b0; l1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      if (j < 3) begin
        v0 = 1'b1; a0 = 32'(j + 10); b0 = 1; c0 = 1'b0; l0 = (j == 2);
      end else begin
        v0 = 1'b0;
      end
      #1;
      chk("t4_ready1", r1, j == 3);
      tick();
      chk("t4_id", oid, exp_ids[j]);
    end
    v1 = 1'b0;
    tick();

    // Backpressure: outputs hold, readies drop; release loads at drain edge.
    do_reset();
    rdy_in = 1'b1;
    v0 = 1'b1; a0 = 100; b0 = 23; c0 = 1'b0; l0 = 1'b1;
    tick();
    v0 = 1'b0;
    chk("t5_s_load", os, 123);
    rdy_in = 1'b0;
    v1 = 1'b1; a1 = 40; b1 = 2; c1 = 1'b1; l1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_stall_ready1", r1, 0);
      tick();
      chk("t5_stall_s", os, 123);
      chk("t5_stall_valid", o_valid, 1);
    end
    rdy_in = 1'b1;
    #1 chk("t5_release_ready1", r1, 1);
    tick();
    v1 = 1'b0;
    chk("t5_new_s", os, 43);
    chk("t5_new_id", oid, 1);
    chk("t5_new_valid", o_valid, 1);
    tick();

    // Reset mid-burst leaves no stale chained carry or lock.
    do_reset();
    rdy_in = 1'b1;
    v0 = 1'b1; a0 = 32'hFFFF_FFFF; b0 = 1; c0 = 1'b0; l0 = 1'b0;
    tick();
    a0 = 32'hFFFF_FFFF; b0 = 0;
    tick();
    rst = 1'b1;
    v1 = 1'b1; a1 = 5; b1 = 5; c1 = 1'b0; l1 = 1'b1;
    #1;
    chk("t6_rst_ready0", r0, 0);
    chk("t6_rst_ready1", r1, 0);
    tick();
    chk("t6_valid", o_valid, 0);
    chk("t6_s", os, 0);
    chk("t6_c", oc, 0);
    chk("t6_last", olast, 0);
    rst = 1'b0;
    a0 = 1; b0 = 1; c0 = 1'b0; l0 = 1'b1;
    #1;
    chk("t6_ready0", r0, 1);
    chk("t6_ready1", r1, 0);
    tick();
    v0 = 1'b0; v1 = 1'b0;
    chk("t6_s_after", os, 2);
    chk("t6_id_after", oid, 0);
    tick();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst    = ($urandom_range(0, 199) == 0);
      rdy_in = ($urandom_range(0, 3) != 0);
      v0 = ($urandom_range(0, 3) != 0);
      a0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? 32'h0000_0001 : $urandom;
      c0 = $urandom_range(0, 1);
      l0 = (m_cnt[0] >= 2) || ($urandom_range(0, 2) == 0);
      v1 = ($urandom_range(0, 3) != 0);
      a1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? 32'h0000_0000 : $urandom;
      c1 = $urandom_range(0, 1);
      l1 = (m_cnt[1] >= 2) || ($urandom_range(0, 2) == 0);
      tick();
    end

    rst = 1'b0; v0 = 1'b0; v1 = 1'b0; rdy_in = 1'b1;
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
